keypad_scanner: RTL and testbench

//  Input-side counterpart of the multiplexed seven-segment driver: scans a 4x4 hex keypad
//  (Pmod KYPD) by driving one active-low row at a time and reading the active-low columns.

---
 rtl/keypad_scanner.sv | 185 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: drives one active-low row at a time, synchronizes the
// active-low columns, debounces press and release, and emits one key_valid pulse
// with the hex code for each accepted press.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    // Synchronizer stages; idle columns are pulled up, so reset to all-high.
    logic [3:0]        col_meta;
    logic [3:0]        col_s;

    state_t            state_q,    state_d;
    logic [SLOT_W-1:0] slot_q,     slot_d;
    logic [DEB_W-1:0]  deb_q,      deb_d;
    logic [1:0]        row_idx_q,  row_idx_d;
    logic [1:0]        cand_row_q, cand_row_d;
    logic [1:0]        cand_col_q, cand_col_d;
    logic [3:0]        row_n_d;
    logic [3:0]        key_code_d;
    logic              key_valid_d;
    logic              key_down_d;

    // Lowest-index low column wins when several are pressed together.
    function automatic logic [1:0] first_low(input logic [3:0] c);
        logic [1:0] idx;
        if (!c[0])      idx = 2'd0;
        else if (!c[1]) idx = 2'd1;
        else if (!c[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    // Keypad legend, indexed by row then column.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= 4'b1111;
            col_s    <= 4'b1111;
        end else begin
            col_meta <= col_n;
            col_s    <= col_meta;
        end
    end

    // Scan / confirm / held next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        deb_d       = deb_q;
        row_idx_d   = row_idx_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        key_code_d  = key_code;
        key_valid_d = 1'b0;
        key_down_d  = key_down;

        unique case (state_q)
            ST_SCAN: begin
                if (slot_q == SLOT_LAST) begin
                    if (col_s == 4'b1111) begin
                        row_idx_d = row_idx_q + 2'd1;
                        slot_d    = '0;
                    end else begin
                        cand_row_d = row_idx_q;
                        cand_col_d = first_low(col_s);
                        deb_d      = '0;
                        state_d    = ST_CONFIRM;
                    end
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end

            ST_CONFIRM: begin
                if (col_s[cand_col_q]) begin
                    // Candidate released before it was stable long enough.
                    row_idx_d = row_idx_q + 2'd1;
                    slot_d    = '0;
                    state_d   = ST_SCAN;
                end else if (deb_q == DEB_LAST) begin
                    key_code_d  = key_map(cand_row_q, cand_col_q);
                    key_valid_d = 1'b1;
                    key_down_d  = 1'b1;
                    deb_d       = '0;
                    state_d     = ST_HELD;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end

            ST_HELD: begin
                if (col_s != 4'b1111) begin
                    // Any activity in the row restarts the release count.
                    deb_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    key_down_d = 1'b0;
                    row_idx_d  = row_idx_q + 2'd1;
                    slot_d     = '0;
                    deb_d      = '0;
                    state_d    = ST_SCAN;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end

            default: begin
                state_d = ST_SCAN;
            end
        endcase

        row_n_d = ~(4'b0001 << row_idx_d);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SCAN;
            slot_q     <= '0;
            deb_q      <= '0;
            row_idx_q  <= 2'd0;
            cand_row_q <= 2'd0;
            cand_col_q <= 2'd0;
            row_n      <= 4'b1110;
            key_code   <= 4'h0;
            key_valid  <= 1'b0;
            key_down   <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            deb_q      <= deb_d;
            row_idx_q  <= row_idx_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            row_n      <= row_n_d;
            key_code   <= key_code_d;
            key_valid  <= key_valid_d;
            key_down   <= key_down_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model driven by the DUT rows,
// a cycle-level reference model, directed cases and randomized presses.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned DEBOUNCE_CNT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] keys = '0;   // bit r*4+c set = key at row r, column c pressed

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'h0, 4'hF, 4'hE, 4'hD};

    // Reference model state
    int         m_mode;   // 0 scanning, 1 confirming, 2 held
    int         m_slot, m_deb, m_row, m_crow, m_ccol;
    logic [3:0] m_s1, m_s2, m_code;
    logic       m_valid, m_down;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    // Keypad: a pressed key shorts its column to its row when that row is driven low.
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && keys[4'(r*4+c)]) col_n[c] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_slot = 0; m_deb = 0; m_row = 0; m_crow = 0; m_ccol = 0;
        m_s1 = 4'hF; m_s2 = 4'hF; m_code = 4'h0; m_valid = 1'b0; m_down = 1'b0;
    endtask

    task automatic m_step();
        logic [3:0] cs;
        cs = m_s2;
        m_s2 = m_s1;
        m_s1 = col_n;
        m_valid = 1'b0;
        case (m_mode)
            0: begin
                if (m_slot == int'(SCAN_DIV) - 1) begin
                    if (cs == 4'hF) begin
                        m_row = (m_row + 1) % 4;
                        m_slot = 0;
                    end else begin
                        m_crow = m_row;
                        for (int i = 3; i >= 0; i--) if (!cs[i]) m_ccol = i;
                        m_deb = 0;
                        m_mode = 1;
                    end
                end else m_slot++;
            end
            1: begin
                if (cs[m_ccol]) begin
                    m_mode = 0; m_row = (m_row + 1) % 4; m_slot = 0;
                end else if (m_deb == int'(DEBOUNCE_CNT) - 1) begin
                    m_code = kmap[4'(m_crow*4 + m_ccol)];
                    m_valid = 1'b1; m_down = 1'b1; m_deb = 0; m_mode = 2;
                end else m_deb++;
            end
            default: begin
                if (cs != 4'hF) m_deb = 0;
                else if (m_deb == int'(DEBOUNCE_CNT) - 1) begin
                    m_down = 1'b0; m_row = (m_row + 1) % 4; m_slot = 0; m_deb = 0; m_mode = 0;
                end else m_deb++;
            end
        endcase
    endtask

    // Reference model advances on the same events as the DUT.
    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else     m_step();
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            logic [3:0] er;
            @(negedge clk);
            er = 4'b0001 << m_row;
            er = ~er;
            chk("row_n", 32'(row_n), 32'(er));
            chk("key_code", 32'(key_code), 32'(m_code));
            chk("key_valid", 32'(key_valid), 32'(m_valid));
            chk("key_down", 32'(key_down), 32'(m_down));
            if (key_valid) pulses++;
        end
    end

    task automatic wait_valid(input string name, input int bound);
        int n;
        n = 0;
        while (key_valid !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (key_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: no key_valid within %0d cycles", name, bound);
        end
        #1;
    endtask

    task automatic wait_down_low(input string name, input int bound, output int n);
        n = 0;
        while (key_down !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (key_down !== 1'b0) begin
            errors++;
            $display("FAIL %s: key_down still high after %0d cycles", name, bound);
        end
        #1;
    endtask

    task automatic wait_mode(input string name, input int mode, input int bound);
        int n;
        n = 0;
        while (m_mode != mode && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_mode != mode) begin
            errors++;
            $display("FAIL %s: model mode %0d not reached within %0d cycles", name, mode, bound);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row_n"}, 32'(row_n), 32'h0000_000E);
        chk({tag, "_code"}, 32'(key_code), 32'd0);
        chk({tag, "_valid"}, 32'(key_valid), 32'd0);
        chk({tag, "_down"}, 32'(key_down), 32'd0);
    endtask

    initial begin
        int p0;
        int n;
        logic [3:0] e;
        logic [3:0] ex;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // 1: idle scanning, one row every SCAN_DIV cycles
        for (int p = 1; p <= 20; p++) begin
            @(negedge clk);
            e  = 4'b0001 << ((p / 4) % 4);
            ex = ~e;
            chk("t1_row", 32'(row_n), 32'(ex));
            chk("t1_valid", 32'(key_valid), 32'd0);
        end

        // 2: clean press of "6", held
        p0 = pulses;
        keys = '0; keys[6] = 1'b1;
        wait_valid("t2_press", 60);
        chk("t2_code", 32'(key_code), 32'h6);
        chk("t2_down", 32'(key_down), 32'd1);
        chk("t2_row", 32'(row_n), 32'hD);
        repeat (40) @(negedge clk);
        #1;
        chk("t2_pulses", 32'(pulses - p0), 32'd1);
        chk("t2_row_held", 32'(row_n), 32'hD);

        // 3: release; key_down falls 2 sync + DEBOUNCE_CNT cycles later, next row driven
        @(negedge clk);
        keys = '0;
        wait_down_low("t3_release", 40, n);
        chk("t3_latency", 32'(n), 32'd10);
        chk("t3_row", 32'(row_n), 32'hB);

        // 4: bouncy press of "D"
        repeat (10) @(negedge clk);
        p0 = pulses;
        repeat (3) begin
            keys = '0; keys[15] = 1'b1;
            repeat (3) @(negedge clk);
            keys = '0;
            repeat (3) @(negedge clk);
        end
        keys[15] = 1'b1;
        wait_valid("t4_press", 80);
        chk("t4_code", 32'(key_code), 32'hD);
        repeat (20) @(negedge clk);
        #1;
        chk("t4_pulses", 32'(pulses - p0), 32'd1);
        keys = '0;
        wait_down_low("t4_release", 40, n);

        // 5: two keys in row 0; lowest column wins, partial release gives nothing
        repeat (10) @(negedge clk);
        p0 = pulses;
        keys = '0; keys[1] = 1'b1; keys[3] = 1'b1;
        wait_valid("t5_press", 60);
        chk("t5_code", 32'(key_code), 32'h2);
        @(negedge clk);
        keys[1] = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("t5_pulses", 32'(pulses - p0), 32'd1);
        chk("t5_down", 32'(key_down), 32'd1);
        keys = '0;
        wait_down_low("t5_release", 40, n);

        // 6: reset during CONFIRM and during HELD, key still held afterwards
        repeat (10) @(negedge clk);
        keys = '0; keys[8] = 1'b1;
        wait_mode("t6_confirm", 1, 60);
        #1 rst = 1'b1;
        #1 chk_reset_vals("t6_rst_confirm");
        @(negedge clk);
        #1 rst = 1'b0;
        wait_valid("t6_fresh1", 60);
        chk("t6_code1", 32'(key_code), 32'h7);
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk_reset_vals("t6_rst_held");
        @(negedge clk);
        #1 rst = 1'b0;
        wait_valid("t6_fresh2", 60);
        chk("t6_code2", 32'(key_code), 32'h7);
        @(negedge clk);
        keys = '0;
        wait_down_low("t6_release", 40, n);

        // Sweep every key once
        for (int k = 0; k < 16; k++) begin
            repeat (5) @(negedge clk);
            keys = '0; keys[4'(k)] = 1'b1;
            wait_valid("sweep_press", 60);
            chk("sweep_code", 32'(key_code), 32'(kmap[4'(k)]));
            @(negedge clk);
            keys = '0;
            wait_down_low("sweep_release", 40, n);
        end

        // Randomized presses with bounce, multi-key and occasional reset
        for (int it = 0; it < 30; it++) begin
            int r, c;
            logic [15:0] kp;
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            kp = '0;
            kp[4'(r*4+c)] = 1'b1;
            if ($urandom_range(0, 3) == 0) kp[4'(r*4 + int'($urandom_range(0, 3)))] = 1'b1;
            repeat ($urandom_range(0, 3)) begin
                keys = kp;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                keys = '0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
            keys = kp;
            repeat ($urandom_range(30, 60)) @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                #1 rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
                repeat ($urandom_range(30, 40)) @(negedge clk);
            end
            repeat ($urandom_range(0, 3)) begin
                keys = '0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                keys = kp;
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
            keys = '0;
            repeat ($urandom_range(20, 40)) @(negedge clk);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
